// File: rtl/cpu_defs.sv
// Shared encodings for the instruction decoder and control FSM:
// opcodes, FSM state codes, writeback-source selects and ALU operations.
package cpu_defs;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WIMM   = 3'd2;
    localparam logic [2:0] S_GETA   = 3'd3;
    localparam logic [2:0] S_GETB   = 3'd4;
    localparam logic [2:0] S_ALU    = 3'd5;
    localparam logic [2:0] S_WREG   = 3'd6;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/cpu_control_if.sv
// Instruction handshake plus every datapath control line driven by cpu_control.
// The controller uses the slave view; the instruction source / datapath the master view.
interface cpu_control_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
);
    logic [WIDTH-1:0]   in;
    logic               load;
    logic               s;
    logic               w;
    logic [REGBITS-1:0] readnum;
    logic [REGBITS-1:0] writenum;
    logic [1:0]         vsel;
    logic               loada;
    logic               loadb;
    logic               loadc;
    logic               loads;
    logic               asel;
    logic               bsel;
    logic [1:0]         shift;
    logic [1:0]         ALUop;
    logic               write;
    logic [WIDTH-1:0]   sximm5;
    logic [WIDTH-1:0]   sximm8;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, write, sximm5, sximm8
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, write, sximm5, sximm8
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational field extraction from the instruction register,
// including the two sign-extended immediates.
module instr_decoder #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
) (
    input  logic [WIDTH-1:0]   ir,
    output logic [2:0]         opcode,
    output logic [1:0]         op,
    output logic [REGBITS-1:0] rn,
    output logic [REGBITS-1:0] rd,
    output logic [1:0]         sh,
    output logic [REGBITS-1:0] rm,
    output logic [WIDTH-1:0]   sximm5,
    output logic [WIDTH-1:0]   sximm8
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[8 +: REGBITS];
    assign rd     = ir[5 +: REGBITS];
    assign sh     = ir[4:3];
    assign rm     = ir[0 +: REGBITS];
    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
endmodule

// File: rtl/cpu_control.sv
// Instruction register and Moore sequencing FSM that steps the datapath through
// one control stage per cycle, handshaking with the instruction source via s/w.
module cpu_control
    import cpu_defs::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
) (
    input logic          clk,
    input logic          reset,
    cpu_control_if.slave bus
);
    logic [WIDTH-1:0]   ir_reg;
    logic [2:0]         state_reg;
    logic [2:0]         state_next;
    logic [2:0]         opcode;
    logic [1:0]         op;
    logic [REGBITS-1:0] rn;
    logic [REGBITS-1:0] rd;
    logic [1:0]         sh;
    logic [REGBITS-1:0] rm;

    instr_decoder #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_dec (
        .ir     (ir_reg),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm5 (bus.sximm5),
        .sximm8 (bus.sximm8)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg    <= '0;
            state_reg <= S_WAIT;
        end else begin
            // IR only accepts a new word while idle, so an executing instruction is stable.
            if (bus.load && state_reg == S_WAIT)
                ir_reg <= bus.in;
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_WAIT;
        case (state_reg)
            S_WAIT:   state_next = bus.s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (opcode == OPC_MOV && op == OP_MOV_IMM)
                    state_next = S_WIMM;
                else if (opcode == OPC_MOV && op == OP_MOV_REG)
                    state_next = S_GETB;
                else if (opcode == OPC_ALU)
                    state_next = S_GETA;
                else
                    state_next = S_WAIT;
            end
            S_WIMM:   state_next = S_WAIT;
            S_GETA:   state_next = S_GETB;
            S_GETB:   state_next = S_ALU;
            S_ALU:    state_next = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WREG;
            S_WREG:   state_next = S_WAIT;
            default:  state_next = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.vsel     = VSEL_C;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = ALU_ADD;
        bus.write    = 1'b0;
        case (state_reg)
            S_WAIT: bus.w = 1'b1;
            S_WIMM: begin
                bus.writenum = rn;
                bus.vsel     = VSEL_IMM8;
                bus.write    = 1'b1;
            end
            S_GETA: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GETB: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            S_ALU: begin
                bus.shift = sh;
                // MOV reg passes B through by adding it to a zeroed A operand.
                if (opcode == OPC_MOV) begin
                    bus.asel  = 1'b1;
                    bus.ALUop = ALU_ADD;
                    bus.loadc = 1'b1;
                end else if (op == OP_CMP) begin
                    bus.ALUop = ALU_SUB;
                    bus.loads = 1'b1;
                end else begin
                    bus.ALUop = op;
                    bus.loadc = 1'b1;
                end
            end
            S_WREG: begin
                bus.writenum = rd;
                bus.vsel     = VSEL_C;
                bus.write    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: stimulus queues expected strobe-cycle snapshots,
// a negedge monitor pops and compares one per cycle in which any strobe is high.
module tb_cpu_control;

    typedef struct packed {
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic [1:0]  shift;
        logic        asel;
        logic        bsel;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic        write;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } ctl_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ctl_t exp_q[$];

    cpu_control_if #(.WIDTH(16), .REGBITS(3)) bus ();

    cpu_control #(.WIDTH(16), .REGBITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t sample();
        ctl_t c;
        c.readnum  = bus.readnum;
        c.writenum = bus.writenum;
        c.vsel     = bus.vsel;
        c.loada    = bus.loada;
        c.loadb    = bus.loadb;
        c.shift    = bus.shift;
        c.asel     = bus.asel;
        c.bsel     = bus.bsel;
        c.aluop    = bus.ALUop;
        c.loadc    = bus.loadc;
        c.loads    = bus.loads;
        c.write    = bus.write;
        c.sximm5   = bus.sximm5;
        c.sximm8   = bus.sximm8;
        return c;
    endfunction

    function automatic ctl_t mk(logic [2:0] rnum, logic [2:0] wnum, logic [1:0] vs,
                                logic la, logic lb, logic [1:0] shf, logic as, logic bs,
                                logic [1:0] aop, logic lc, logic ls, logic wr,
                                logic [15:0] s5, logic [15:0] s8);
        ctl_t c;
        c.readnum = rnum; c.writenum = wnum; c.vsel = vs;
        c.loada = la; c.loadb = lb; c.shift = shf; c.asel = as; c.bsel = bs;
        c.aluop = aop; c.loadc = lc; c.loads = ls; c.write = wr;
        c.sximm5 = s5; c.sximm8 = s8;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    // Monitor: every cycle with a strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (bus.loada || bus.loadb || bus.loadc || bus.loads || bus.write)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got=%h want=none", sample());
            end else begin
                chk("strobe_cycle", 64'(sample()), 64'(exp_q.pop_front()));
            end
        end
    end

    // Issue one instruction from S_WAIT; optionally attempt a load of 0xFFFF at step inj.
    task automatic run(input string name, input logic [15:0] instr, input int lat, input int inj);
        int cnt;
        bus.in   = instr;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        cnt = 1;
        while (!bus.w && cnt < 20) begin
            if (cnt == inj) begin
                bus.in   = 16'hFFFF;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        bus.load = 1'b0;
        chk({name, "_latency"}, 64'(cnt), 64'(lat));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(posedge clk); #1;
        chk("reset_w", 64'(bus.w), 64'd1);
        chk("reset_ctl", 64'(sample()), 64'(ctl_t'(0)));
        chk("reset_ir", 64'(dut.ir_reg), 64'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // MOV R0,#7
        exp_q.push_back(mk(0, 0, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'h0007, 16'h0007));
        run("mov_imm7", 16'hD007, 3, 0);

        // MOV R1,#-1
        exp_q.push_back(mk(0, 1, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'hFFFF, 16'hFFFF));
        run("mov_imm_neg", 16'hD1FF, 3, 0);

        // ADD R2,R1,R0,LSL#1
        exp_q.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 1, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 2, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'h0008, 16'h0048));
        run("add", 16'hA148, 6, 0);

        // CMP R1,R0
        exp_q.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 16'h0000));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 16'h0000));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b01, 0, 1, 0, 16'h0000, 16'h0000));
        run("cmp", 16'hA900, 5, 0);

        // MOV R5,R1,LSL#1
        exp_q.push_back(mk(1, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0009, 16'hFFA9));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b01, 1, 0, 2'b00, 1, 0, 0, 16'h0009, 16'hFFA9));
        exp_q.push_back(mk(0, 5, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'h0009, 16'hFFA9));
        run("mov_reg", 16'hC0A9, 5, 0);

        // AND R3,R2,R1
        exp_q.push_back(mk(2, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0001, 16'h0061));
        exp_q.push_back(mk(1, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0001, 16'h0061));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b10, 1, 0, 0, 16'h0001, 16'h0061));
        exp_q.push_back(mk(0, 3, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'h0001, 16'h0061));
        run("and", 16'hB261, 6, 0);

        // MVN R4,R2,LSR#1 (Rn field = R0 is still read in GETA)
        exp_q.push_back(mk(0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'hFFF2, 16'hFF92));
        exp_q.push_back(mk(2, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'hFFF2, 16'hFF92));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b10, 0, 0, 2'b11, 1, 0, 0, 16'hFFF2, 16'hFF92));
        exp_q.push_back(mk(0, 4, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'hFFF2, 16'hFF92));
        run("mvn", 16'hB892, 6, 0);

        // NOP: DECODE then straight back to WAIT, no strobes queued
        run("nop", 16'h0000, 2, 0);

        // ADD again with a load of 0xFFFF attempted during GETA
        exp_q.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 1, 0, 0, 16'h0008, 16'h0048));
        exp_q.push_back(mk(0, 2, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 16'h0008, 16'h0048));
        run("add_load_ignored", 16'hA148, 6, 2);
        chk("ir_kept", 64'(dut.ir_reg), 64'hA148);

        // ADD aborted by asynchronous reset in the middle of GETB
        exp_q.push_back(mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 16'h0008, 16'h0048));
        bus.in   = 16'hA148;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("getb_before_abort", 64'(bus.loadb), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_w", 64'(bus.w), 64'd1);
        chk("abort_ctl", 64'(sample()), 64'(ctl_t'(0)));
        chk("abort_ir", 64'(dut.ir_reg), 64'h0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_idle_w", 64'(bus.w), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Instruction register, decoder and sequencing FSM that sits directly upstream of the datapath.
- Latches a 16-bit instruction, then drives every datapath control input one stage at a time: readnum, writenum, vsel, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, write, sximm5 and sximm8.
- Uses a start/wait handshake toward the instruction source.
- Supports MOV Rn,#imm8; MOV Rd,Rm{,sh}; ADD, CMP, AND and MVN.

Parameters:
- WIDTH, 16, instruction and immediate width.
- REGBITS, 3, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in  in  16  instruction word.
- load  in  1  capture `in` into the IR.
- s  in  1  start execution of the IR contents.
- w  out  1  idle/ready; high only in S_WAIT.
- readnum  out  3  register read index.
- writenum  out  3  register write index.
- vsel  out  2  writeback source: 00=C, 01=PC, 10=sximm8, 11=mdata.
- loada, loadb, loadc, loads  out  1 each  datapath register enables.
- asel  out  1  1 = A operand forced to zero.
- bsel  out  1  1 = B operand is sximm5.
- shift  out  2  shifter control.
- ALUop  out  2  00 ADD, 01 SUB(CMP), 10 AND, 11 MVN.
- write  out  1  register file write strobe.
- sximm5  out  16  sign-extended ir[4:0].
- sximm8  out  16  sign-extended ir[7:0].

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - ir=0 and state=S_WAIT.
  - w=1; every other control output is 0.
  - Reset asserted mid-instruction aborts it immediately; no write strobe may follow.
- IR: on posedge clk, if load=1 and state=S_WAIT, then ir<=in. load in any other state is ignored.
- IR fields: opcode=ir[15:13], op=ir[12:11], Rn=ir[10:8], Rd=ir[7:5], sh=ir[4:3], Rm=ir[2:0].
- sximm5 and sximm8 are combinational from ir at all times.
- All control outputs are Moore outputs of state+ir. Default value is 0 (readnum/writenum default 0).
- FSM:
  - S_WAIT: w=1. If s=1 -> S_DECODE. If load and s are high in the same cycle, the new ir is the one decoded.
  - S_DECODE (no strobes) branches on opcode/op:
    - {110,10} -> S_WIMM
    - {110,00} -> S_GETB
    - {101,xx} -> S_GETA
    - any other encoding -> S_WAIT (treated as NOP)
  - S_WIMM: writenum=Rn, vsel=10, write=1 -> S_WAIT.
  - S_GETA: readnum=Rn, loada=1 -> S_GETB.
  - S_GETB: readnum=Rm, loadb=1 -> S_ALU.
  - S_ALU: shift=sh, bsel=0.
    - MOV reg: asel=1, ALUop=00, loadc=1 -> S_WREG.
    - ADD/AND/MVN: asel=0, ALUop=op, loadc=1 -> S_WREG.
    - CMP: asel=0, ALUop=01, loads=1, loadc=0 -> S_WAIT.
  - S_WREG: writenum=Rd, vsel=00, write=1 -> S_WAIT.
- Latency from the edge that samples s to w high again:
  - MOV imm: 3 cycles.
  - MOV reg: 5 cycles.
  - CMP: 5 cycles.
  - ADD, AND, MVN: 6 cycles.
- Every strobe is high for exactly one cycle per instruction.
- s is ignored outside S_WAIT. If s is held high, back-to-back instructions start on every return to S_WAIT.
- Unreachable state encodings return to S_WAIT on the next edge.

Decomposition:
- Shared package cpu_defs holds:
  - opcode/op constants.
  - state encoding.
  - vsel encodings (VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA).
  - ALUop encodings.
- One sub-module, instr_decoder: purely combinational. Extracts the IR fields and produces sximm5/sximm8.
- The FSM and IR live in cpu_control.

Test Plan:
- Reset, then in=0xD007, load=1, s=1 for one cycle (MOV R0,#7) -> S_WIMM cycle shows writenum=0, vsel=10, sximm8=0x0007, write=1; w high 3 cycles after s sampled.
- in=0xD1FF (MOV R1,#-1) -> sximm8=0xFFFF, writenum=1, single write pulse.
- in=0xA148 (ADD R2,R1,R0,LSL#1) -> following sequence, then w=1:
  - GETA: readnum=1, loada=1.
  - GETB: readnum=0, loadb=1.
  - ALU: shift=01, ALUop=00, asel=0, bsel=0, loadc=1.
  - WREG: writenum=2, vsel=00, write=1.
- in=0xA900 (CMP R1,R0) -> ALU cycle has ALUop=01, loads=1, loadc=0; write never asserted; w high 5 cycles after s.
- in=0x0000 with s=1 -> DECODE then WAIT with zero strobes. Separately, load=1 with in=0xFFFF during S_GETA of an ADD -> ir unchanged, ADD completes normally.
- Start ADD, assert reset asynchronously mid-S_GETB -> w=1 and all strobes 0 before the next edge; no write pulse afterward; ir=0.
